// File: rtl/circle_seg_pkg.sv
// Shared types and helpers for the circle animation: sequencer states,
// per-digit segment patterns and the path-position to digit mapping.
package circle_seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } seq_state_e;

    // Segment order {g,f,e,d,c,b,a}; upper circle = a,b,f,g, lower = c,d,e,g.
    localparam logic [6:0] HIGH_CIRCLE = 7'b110_0011;
    localparam logic [6:0] LOW_CIRCLE  = 7'b101_1100;

    typedef struct packed {
        int   digit;
        logic row;
    } digit_sel_t;

    function automatic digit_sel_t map_position(input int pos, input int num_digits);
        digit_sel_t sel;
        if (pos < num_digits) begin
            sel.digit = pos;
            sel.row   = 1'b1;
        end else begin
            sel.digit = 2 * num_digits - 1 - pos;
            sel.row   = 1'b0;
        end
        return sel;
    endfunction

endpackage

// File: rtl/circle_path_sequencer_if.sv
// Control/status bundle between a controller and the circle path sequencer.
interface circle_path_sequencer_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int POS_W = $clog2(2 * NUM_DIGITS);

    logic                  run_i;
    logic                  clear_i;
    logic                  dir_i;
    logic [NUM_DIGITS-1:0] row_o;
    logic [NUM_DIGITS-1:0] enable_o;
    logic [POS_W-1:0]      pos_o;
    logic                  wrap_o;

    modport master (
        output run_i, clear_i, dir_i,
        input  row_o, enable_o, pos_o, wrap_o
    );

    modport slave (
        input  run_i, clear_i, dir_i,
        output row_o, enable_o, pos_o, wrap_o
    );

endinterface

// File: rtl/step_prescaler.sv
// Divides the clock into animation steps: o_step pulses on the last count
// of every TICK_DIV enabled cycles; the count holds while disabled.
module step_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clear,
    output logic o_step
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;

    assign o_step = i_en && (r_count == LAST_CNT);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_step ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/circle_path_sequencer.sv
// Moves one circle around a multi-digit 7-segment display: left to right on
// the upper half, right to left on the lower half, with pause/clear/direction.
module circle_path_sequencer
    import circle_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    circle_path_sequencer_if.slave  bus
);
    localparam int POS_W = $clog2(2 * NUM_DIGITS);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(2 * NUM_DIGITS - 1);

    seq_state_e            r_state, w_state_next;
    logic [POS_W-1:0]      r_pos, w_pos_next;
    logic [NUM_DIGITS-1:0] r_row, r_enable, w_row_next, w_enable_next;
    logic                  r_wrap, w_wrap_next;
    logic                  w_step;
    digit_sel_t            w_sel;

    // clear_i gates the count enable so a clear can never coincide with a step.
    step_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .i_en    ((r_state == RUN) && !bus.clear_i),
        .i_clear (bus.clear_i),
        .o_step  (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pos    <= '0;
            r_row    <= '0;
            r_enable <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pos    <= w_pos_next;
            r_row    <= w_row_next;
            r_enable <= w_enable_next;
            r_wrap   <= w_wrap_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a variable unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.run_i)  w_state_next = RUN;
            RUN:     if (!bus.run_i) w_state_next = PAUSE;
            PAUSE:   if (bus.run_i)  w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
        if (bus.clear_i) w_state_next = IDLE;
    end

    always_comb begin
        w_pos_next  = r_pos;
        w_wrap_next = 1'b0;
        if (bus.clear_i) begin
            w_pos_next = '0;
        end else if (w_step) begin
            if (bus.dir_i) begin
                w_wrap_next = (r_pos == '0);
                w_pos_next  = w_wrap_next ? LAST_POS : r_pos - 1'b1;
            end else begin
                w_wrap_next = (r_pos == LAST_POS);
                w_pos_next  = w_wrap_next ? '0 : r_pos + 1'b1;
            end
        end
    end

    // Decode from next-state values so the registered outputs move with pos.
    always_comb begin
        w_sel         = map_position(int'(w_pos_next), NUM_DIGITS);
        w_row_next    = '0;
        w_enable_next = '0;
        if (w_state_next != IDLE) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (d == w_sel.digit) begin
                    w_enable_next[d] = 1'b1;
                    w_row_next[d]    = w_sel.row;
                end
            end
        end
    end

    assign bus.row_o    = r_row;
    assign bus.enable_o = r_enable;
    assign bus.pos_o    = r_pos;
    assign bus.wrap_o   = r_wrap;

endmodule

// File: tb/tb_circle_path_sequencer.sv
// Self-checking bench: directed animation scenarios followed by random
// run/pause/clear/reset/direction traffic against a behavioural model.
module tb_circle_path_sequencer;

    localparam int N  = 4;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    circle_path_sequencer_if #(.NUM_DIGITS(N)) bus ();

    circle_path_sequencer #(.NUM_DIGITS(N), .TICK_DIV(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: whether a circle is visible, whether time is flowing,
    // where on the 2N-long loop it is, and run cycles since the last step.
    bit m_shown, m_running, m_wrap;
    int m_pos, m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit run, input bit clr, input bit dir);
        if (r || clr) begin
            m_shown = 0; m_running = 0; m_wrap = 0; m_pos = 0; m_count = 0;
        end else begin
            m_wrap = 0;
            if (m_running) begin
                if (m_count == TD - 1) begin
                    m_count = 0;
                    m_wrap  = dir ? (m_pos == 0) : (m_pos == 2 * N - 1);
                    m_pos   = (m_pos + (dir ? 2 * N - 1 : 1)) % (2 * N);
                end else begin
                    m_count++;
                end
            end
            if (run) begin
                m_running = 1;
                m_shown   = 1;
            end else begin
                m_running = 0;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_enable();
        if (!m_shown) return '0;
        return (m_pos < N) ? N'(1) << m_pos : N'(1) << (2 * N - 1 - m_pos);
    endfunction

    function automatic logic [N-1:0] exp_row();
        if (!m_shown || m_pos >= N) return '0;
        return N'(1) << m_pos;
    endfunction

    task automatic cycle(input bit r, input bit run, input bit clr, input bit dir);
        rst         = r;
        bus.run_i   = run;
        bus.clear_i = clr;
        bus.dir_i   = dir;
        model_step(r, run, clr, dir);
        @(posedge clk);
        @(negedge clk);
        check("enable", 32'(bus.enable_o), 32'(exp_enable()));
        check("row",    32'(bus.row_o),    32'(exp_row()));
        check("pos",    32'(bus.pos_o),    32'(m_pos));
        check("wrap",   32'(bus.wrap_o),   32'(m_wrap));
    endtask

    initial begin
        rst         = 1'b1;
        bus.run_i   = 1'b0;
        bus.clear_i = 1'b0;
        bus.dir_i   = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("reset_enable", 32'(bus.enable_o), 32'h0);
        check("reset_row",    32'(bus.row_o),    32'h0);
        check("reset_pos",    32'(bus.pos_o),    32'h0);

        // Start, first step
        cycle(0, 1, 0, 0);
        check("start_enable", 32'(bus.enable_o), 32'h1);
        check("start_row",    32'(bus.row_o),    32'h1);
        repeat (4) cycle(0, 1, 0, 0);
        check("step1_pos",    32'(bus.pos_o),    32'h1);
        check("step1_enable", 32'(bus.enable_o), 32'h2);

        // Finish the clockwise loop
        repeat (28) cycle(0, 1, 0, 0);
        check("loop_pos",  32'(bus.pos_o),  32'h0);
        check("loop_wrap", 32'(bus.wrap_o), 32'h1);

        // Counter-clockwise wrap from position 0
        cycle(0, 1, 0, 1);
        check("wrap_drop", 32'(bus.wrap_o), 32'h0);
        repeat (3) cycle(0, 1, 0, 1);
        check("ccw_pos",    32'(bus.pos_o),    32'h7);
        check("ccw_enable", 32'(bus.enable_o), 32'h1);
        check("ccw_row",    32'(bus.row_o),    32'h0);
        check("ccw_wrap",   32'(bus.wrap_o),   32'h1);

        // Pause after two counted cycles, resume
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0);
            check("pause_pos",    32'(bus.pos_o),    32'h7);
            check("pause_enable", 32'(bus.enable_o), 32'h1);
        end
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("resume_hold", 32'(bus.pos_o), 32'h7);
        cycle(0, 1, 0, 0);
        check("resume_step", 32'(bus.pos_o),  32'h0);
        check("resume_wrap", 32'(bus.wrap_o), 32'h1);

        // Clear together with run at position 5
        repeat (20) cycle(0, 1, 0, 0);
        check("pre_clear_pos", 32'(bus.pos_o), 32'h5);
        cycle(0, 1, 1, 0);
        check("clear_enable", 32'(bus.enable_o), 32'h0);
        check("clear_pos",    32'(bus.pos_o),    32'h0);
        cycle(0, 1, 0, 0);
        check("after_clear_enable", 32'(bus.enable_o), 32'h1);

        // Reset mid-run at position 3
        repeat (12) cycle(0, 1, 0, 0);
        check("pre_rst_pos", 32'(bus.pos_o), 32'h3);
        cycle(1, 1, 0, 0);
        check("rst_enable", 32'(bus.enable_o), 32'h0);
        check("rst_pos",    32'(bus.pos_o),    32'h0);
        cycle(0, 1, 0, 0);
        check("rerun_enable", 32'(bus.enable_o), 32'h1);
        repeat (4) cycle(0, 1, 0, 0);
        check("rerun_pos", 32'(bus.pos_o), 32'h1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 99) == 0,
                  $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
